load_stall_sequencer: RTL and testbench
=======================================

Name: load_stall_sequencer

Overview:
Consumer side of the load-use stall request raised during decode. It turns a stall request into pipeline hold/bubble controls and tracks the outstanding load until data-memory read data returns. It then pulses unlock back to the stall-request logic. It sits in the core's hazard-control path between ID (requester), the PC/IF-ID/ID-EX pipeline registers, and the data-memory response.

Parameters:
MAX_WAIT, 16, cycles allowed in WAIT_MEM before timeout; legal range 2..255
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk_i  in  1  core clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
stall_req_i  in  1  load-use stall request from decode (combinational)
flush_i  in  1  pipeline redirect (branch/jump/trap); kills the stall
dmem_rvalid_i  in  1  data-memory read data valid for the outstanding load
pc_hold_o  out  1  freeze PC register
ifid_hold_o  out  1  freeze IF/ID register
idex_bubble_o  out  1  load NOP (I_NOP) into ID/EX instead of decoded instruction
unlock_o  out  1  one-cycle pulse: load data now forwardable, drop stall
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky: WAIT_MEM exceeded MAX_WAIT
stall_cycles_o  out  CNT_W  saturating count of cycles with pc_hold_o=1

Behaviour:
- Reset (rst_ni=0, async): state=IDLE, wait counter=0, stall_cycles_o=0, timeout_o=0. All other outputs are 0 combinationally.
- FSM states: IDLE, WAIT_MEM, RELEASE.
- Outputs are Mealy in IDLE and Moore elsewhere. pc_hold_o, ifid_hold_o and idex_bubble_o are always equal.
- IDLE:
  - stall_req_i=1 and flush_i=0: assert all holds in the same cycle (zero latency).
    - Next state is RELEASE if dmem_rvalid_i=1 this cycle.
    - Otherwise next state is WAIT_MEM, with wait counter cleared to 0.
  - stall_req_i=0: holds stay 0 and the FSM stays in IDLE.
- WAIT_MEM:
  - Holds are 1 every cycle. The wait counter increments by 1 each cycle.
  - dmem_rvalid_i=1: next state RELEASE.
  - Else, if wait counter == MAX_WAIT-1: set timeout_o (sticky), next state RELEASE.
  - stall_req_i is ignored in this state.
- RELEASE (exactly 1 cycle):
  - Holds are 0 and unlock_o=1. Next state IDLE.
  - stall_req_i is ignored in this cycle. The requester masks its request while unlock_o=1.
  - A new request is honoured from the following IDLE cycle.
- flush_i=1 in any state:
  - Holds are 0 and unlock_o=0 that cycle. Next state IDLE, wait counter cleared.
  - flush_i takes priority over stall_req_i, dmem_rvalid_i and timeout.
  - timeout_o is not cleared by flush_i.
- dmem_rvalid_i and timeout in the same WAIT_MEM cycle: rvalid wins and timeout_o stays unchanged.
- stall_cycles_o:
  - Increments each cycle pc_hold_o=1, including the Mealy cycle in IDLE.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Cleared only by reset.
- A reset asserted mid-WAIT_MEM returns the block to IDLE immediately. No unlock pulse is issued.

Test Plan:
- Single-cycle memory:
  - Stimulus: stall_req_i=1 with dmem_rvalid_i=1 in the same cycle.
  - Response: holds=1 for 1 cycle, then unlock_o=1 for 1 cycle; stall_cycles_o=1; busy_o high for 1 cycle.
- 3-cycle memory:
  - Stimulus: stall_req_i=1 at cycle 0; dmem_rvalid_i=1 at cycle 3.
  - Response: holds=1 for cycles 0-3; unlock_o=1 at cycle 4; stall_cycles_o=4; idex_bubble_o high for 4 cycles.
- Timeout (MAX_WAIT=4):
  - Stimulus: stall request, rvalid never asserted.
  - Response: holds=1 for cycles 0-4; timeout_o=1 from cycle 5 and sticky; unlock_o pulse at cycle 5; stall_cycles_o=5.
- Flush in WAIT_MEM:
  - Stimulus: stall_req_i at cycle 0, flush_i=1 at cycle 2, rvalid at cycle 3.
  - Response: holds drop at cycle 2; no unlock_o ever; state IDLE at cycle 3; rvalid ignored; stall_cycles_o=2.
- Back-to-back requests:
  - Stimulus: stall_req_i held high throughout, rvalid at cycle 1.
  - Response: unlock_o at cycle 2 with holds=0; new stall accepted at cycle 3 (holds=1).
- Async reset at cycle 2 of WAIT_MEM:
  - Response: all outputs 0 immediately, stall_cycles_o=0, timeout_o=0, no unlock after reset release.

Source files
------------

// File: rtl/load_stall_sequencer_if.sv
// load_stall_sequencer_if
//   Groups the hazard-control signals that connect the load stall sequencer
//   to decode, the pipeline registers and the data-memory response path.
//   master : decode/redirect/memory side (drives requests, observes controls)
//   slave  : load_stall_sequencer
//   Signals:
//     stall_req_i    load-use stall request from decode
//     flush_i        pipeline redirect, kills any stall in progress
//     dmem_rvalid_i  read data valid for the outstanding load
//     pc_hold_o      freeze PC
//     ifid_hold_o    freeze IF/ID
//     idex_bubble_o  insert NOP into ID/EX
//     unlock_o       one-cycle pulse, load data forwardable
//     busy_o         sequencer not idle
//     timeout_o      sticky memory-wait timeout flag
//     stall_cycles_o saturating count of held cycles
interface load_stall_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             stall_req_i;
  logic             flush_i;
  logic             dmem_rvalid_i;
  logic             pc_hold_o;
  logic             ifid_hold_o;
  logic             idex_bubble_o;
  logic             unlock_o;
  logic             busy_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport master (
    output stall_req_i, flush_i, dmem_rvalid_i,
    input  pc_hold_o, ifid_hold_o, idex_bubble_o, unlock_o, busy_o,
           timeout_o, stall_cycles_o
  );

  modport slave (
    input  stall_req_i, flush_i, dmem_rvalid_i,
    output pc_hold_o, ifid_hold_o, idex_bubble_o, unlock_o, busy_o,
           timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/load_stall_sequencer.sv
// load_stall_sequencer
//   Turns a load-use stall request into PC/IF-ID hold and ID-EX bubble
//   controls, waits for the outstanding load's read data (or a timeout), then
//   pulses unlock back to the requester for one cycle.
//   Ports:
//     clk_i   core clock, rising edge
//     rst_ni  asynchronous active-low reset
//     bus     load_stall_sequencer_if.slave (requests in, controls out)
//   Parameters:
//     MAX_WAIT  cycles allowed in WAIT_MEM before timeout (2..255)
//     CNT_W     width of the stall-cycle counter
module load_stall_sequencer #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  load_stall_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_MEM,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             r_timeout;
  logic             w_timeout_set;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hold;
  logic             w_unlock;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      if (w_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // The IDLE hold is Mealy on stall_req_i, so it is gated with rst_ni to keep
  // every control low while reset is asserted.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_set = 1'b0;
    w_hold        = 1'b0;
    w_unlock      = 1'b0;
    if (!rst_ni) begin
      w_state_nxt = ST_IDLE;
      w_wait_nxt  = '0;
    end else if (bus.flush_i) begin
      w_state_nxt = ST_IDLE;
      w_wait_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.stall_req_i) begin
            w_hold      = 1'b1;
            w_wait_nxt  = '0;
            w_state_nxt = bus.dmem_rvalid_i ? ST_RELEASE : ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          w_hold     = 1'b1;
          w_wait_nxt = r_wait_cnt + 8'd1;
          if (bus.dmem_rvalid_i) begin
            w_state_nxt = ST_RELEASE;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            w_timeout_set = 1'b1;
            w_state_nxt   = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          w_unlock    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pc_hold_o      = w_hold;
  assign bus.ifid_hold_o    = w_hold;
  assign bus.idex_bubble_o  = w_hold;
  assign bus.unlock_o       = w_unlock;
  assign bus.busy_o         = (r_state != ST_IDLE);
  assign bus.timeout_o      = r_timeout;
  assign bus.stall_cycles_o = r_stall_cnt;

endmodule

// File: tb/tb_load_stall_sequencer.sv
module tb_load_stall_sequencer;
  localparam int MW = 4;
  localparam int CW = 4;

  typedef struct {
    bit s;
    bit f;
    bit r;
    bit h;
    bit u;
    bit b;
    bit t;
    int c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  load_stall_sequencer_if #(.CNT_W(CW)) bus ();

  load_stall_sequencer #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  function automatic vec_t mk(bit s, bit f, bit r, bit h, bit u, bit b, bit t, int c);
    vec_t v;
    v.s = s; v.f = f; v.r = r; v.h = h; v.u = u; v.b = b; v.t = t; v.c = c;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_out(string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, " pc_hold"},    int'(bus.pc_hold_o),     int'(e.h));
    chk({tag, " ifid_hold"},  int'(bus.ifid_hold_o),   int'(e.h));
    chk({tag, " bubble"},     int'(bus.idex_bubble_o), int'(e.h));
    chk({tag, " unlock"},     int'(bus.unlock_o),      int'(e.u));
    chk({tag, " busy"},       int'(bus.busy_o),        int'(e.b));
    chk({tag, " timeout"},    int'(bus.timeout_o),     int'(e.t));
    chk({tag, " stall_cnt"},  int'(bus.stall_cycles_o), e.c);
  endtask

  // One cycle: drive inputs after the falling edge, record expectation,
  // sample once combinational outputs have settled.
  task automatic drive(vec_t v, string tag);
    @(negedge clk);
    bus.stall_req_i   = v.s;
    bus.flush_i       = v.f;
    bus.dmem_rvalid_i = v.r;
    sb_q.push_back(v);
    #1;
    compare_out(tag);
  endtask

  initial begin
    // Single-cycle memory
    tbl.push_back(mk(1,0,1, 1,0,0,0, 0));
    tbl.push_back(mk(0,0,0, 0,1,1,0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 1));
    // 3-cycle memory (request kept high while waiting: ignored)
    tbl.push_back(mk(1,0,0, 1,0,0,0, 1));
    tbl.push_back(mk(1,0,0, 1,0,1,0, 2));
    tbl.push_back(mk(1,0,0, 1,0,1,0, 3));
    tbl.push_back(mk(1,0,1, 1,0,1,0, 4));
    tbl.push_back(mk(0,0,0, 0,1,1,0, 5));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 5));
    // Timeout with MAX_WAIT=4
    tbl.push_back(mk(1,0,0, 1,0,0,0, 5));
    tbl.push_back(mk(0,0,0, 1,0,1,0, 6));
    tbl.push_back(mk(0,0,0, 1,0,1,0, 7));
    tbl.push_back(mk(0,0,0, 1,0,1,0, 8));
    tbl.push_back(mk(0,0,0, 1,0,1,0, 9));
    tbl.push_back(mk(0,0,0, 0,1,1,1, 10));
    tbl.push_back(mk(0,0,0, 0,0,0,1, 10));
    // Flush in WAIT_MEM, late rvalid ignored
    tbl.push_back(mk(1,0,0, 1,0,0,1, 10));
    tbl.push_back(mk(0,0,0, 1,0,1,1, 11));
    tbl.push_back(mk(0,1,0, 0,0,1,1, 12));
    tbl.push_back(mk(0,0,1, 0,0,0,1, 12));
    tbl.push_back(mk(0,0,0, 0,0,0,1, 12));
    // Back-to-back requests, then counter saturation at 15
    tbl.push_back(mk(1,0,0, 1,0,0,1, 12));
    tbl.push_back(mk(1,0,1, 1,0,1,1, 13));
    tbl.push_back(mk(1,0,0, 0,1,1,1, 14));
    tbl.push_back(mk(1,0,0, 1,0,0,1, 14));
    tbl.push_back(mk(1,1,0, 0,0,1,1, 15));
    tbl.push_back(mk(1,0,0, 1,0,0,1, 15));
    tbl.push_back(mk(1,0,1, 1,0,1,1, 15));
    tbl.push_back(mk(0,0,0, 0,1,1,1, 15));
    // Flush beats a request in IDLE
    tbl.push_back(mk(1,1,0, 0,0,0,1, 15));
    tbl.push_back(mk(0,0,0, 0,0,0,1, 15));

    // Reset state, with a request present that must not show through
    rst_ni            = 1'b0;
    bus.stall_req_i   = 1'b1;
    bus.flush_i       = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    sb_q.push_back(mk(1,0,1, 0,0,0,0, 0));
    compare_out("reset");
    @(negedge clk);
    bus.stall_req_i   = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    rst_ni            = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], $sformatf("v%0d", i));
    end

    // Async reset in WAIT_MEM: everything drops immediately, no unlock later
    drive(mk(1,0,0, 1,0,0,1, 15), "ar0");
    drive(mk(1,0,0, 1,0,1,1, 15), "ar1");
    drive(mk(1,0,0, 1,0,1,1, 15), "ar2");
    #1;
    rst_ni = 1'b0;
    #1;
    sb_q.push_back(mk(1,0,0, 0,0,0,0, 0));
    compare_out("ar_mid");
    @(negedge clk);
    bus.stall_req_i = 1'b0;
    rst_ni          = 1'b1;
    drive(mk(0,0,0, 0,0,0,0, 0), "ar3");
    drive(mk(0,0,0, 0,0,0,0, 0), "ar4");

    // rvalid and timeout in the same WAIT_MEM cycle: rvalid wins
    drive(mk(1,0,0, 1,0,0,0, 0), "co0");
    drive(mk(0,0,0, 1,0,1,0, 1), "co1");
    drive(mk(0,0,0, 1,0,1,0, 2), "co2");
    drive(mk(0,0,0, 1,0,1,0, 3), "co3");
    drive(mk(0,0,1, 1,0,1,0, 4), "co4");
    drive(mk(0,0,0, 0,1,1,0, 5), "co5");
    drive(mk(0,0,0, 0,0,0,0, 5), "co6");

    // Flush during RELEASE suppresses the unlock pulse
    drive(mk(1,0,1, 1,0,0,0, 5), "fr0");
    drive(mk(0,1,0, 0,0,1,0, 6), "fr1");
    drive(mk(0,0,0, 0,0,0,0, 6), "fr2");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
